// File: rtl/sdram_ex_pkg.sv
// Shared types and constants for the SDRAM example read checker.
// The lane LFSR step lives here so the lane module and any model agree on it.
package sdram_ex_pkg;

  localparam int COUNT_W = 16;
  localparam int LANE_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Galois form of x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [LANE_W-1:0] LFSR_TAPS = 8'h1D;

  function automatic logic [LANE_W-1:0] lfsr8_step(input logic [LANE_W-1:0] s);
    return {s[LANE_W-2:0], 1'b0} ^ (s[LANE_W-1] ? LFSR_TAPS : {LANE_W{1'b0}});
  endfunction

endpackage

// File: rtl/sdramController_ex_lfsr8.sv
// One 8-bit pattern lane: sits at its seed unless enabled, and steps once
// per cycle in which pause is low.
module sdramController_ex_lfsr8
  import sdram_ex_pkg::*;
#(
  parameter logic [LANE_W-1:0] SEED = 8'h20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              enable,
  input  logic              pause,
  output logic [LANE_W-1:0] value
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= SEED;
    end else if (load || !enable) begin
      value <= SEED;
    end else if (!pause) begin
      value <= lfsr8_step(value);
    end
  end

endmodule

// File: rtl/sdram_ex_read_checker.sv
// Compares a stream of SDRAM read words against a per-byte LFSR pattern and
// reports mismatch count plus the index/data of the first mismatch.
module sdram_ex_read_checker
  import sdram_ex_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SEED       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [COUNT_W-1:0]    num_words,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rdata_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [COUNT_W-1:0]    err_count,
  output logic [COUNT_W-1:0]    first_err_index,
  output logic [DATA_WIDTH-1:0] first_err_data
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_W;

  state_t                state_reg, state_next;
  logic [COUNT_W-1:0]    word_cnt_reg;
  logic [COUNT_W-1:0]    num_words_reg;
  logic [COUNT_W-1:0]    err_count_reg;
  logic [COUNT_W-1:0]    first_err_index_reg;
  logic [DATA_WIDTH-1:0] first_err_data_reg;
  logic [DATA_WIDTH-1:0] expected_word;
  logic                  in_check;
  logic                  accept;
  logic                  last_word;
  logic                  mismatch;

  assign in_check  = (state_reg == CHECK);
  // abort wins over a coincident valid, so that word is neither counted nor stepped
  assign accept    = in_check && rdata_valid && !abort;
  assign last_word = (word_cnt_reg == num_words_reg - 16'd1);
  assign mismatch  = (rdata != expected_word);

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [LANE_W-1:0] LANE_SEED = LANE_W'((SEED + gi) % 256);
      sdramController_ex_lfsr8 #(
        .SEED (LANE_SEED)
      ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (1'b0),
        .enable  (in_check),
        .pause   (!accept),
        .value   (expected_word[gi*LANE_W +: LANE_W])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = (num_words == '0) ? DONE : CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_next = IDLE;
        end else if (rdata_valid && last_word) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt_reg        <= '0;
      num_words_reg       <= '0;
      err_count_reg       <= '0;
      first_err_index_reg <= '0;
      first_err_data_reg  <= '0;
    end else if (state_reg != CHECK) begin
      if (start) begin
        word_cnt_reg        <= '0;
        num_words_reg       <= num_words;
        err_count_reg       <= '0;
        first_err_index_reg <= '0;
        first_err_data_reg  <= '0;
      end
    end else if (accept) begin
      word_cnt_reg <= word_cnt_reg + 16'd1;
      if (mismatch) begin
        if (err_count_reg != 16'hFFFF) begin
          err_count_reg <= err_count_reg + 16'd1;
        end
        // a zero count means no mismatch has been captured yet in this pass
        if (err_count_reg == '0) begin
          first_err_index_reg <= word_cnt_reg;
          first_err_data_reg  <= rdata;
        end
      end
    end
  end

  assign busy            = in_check;
  assign done            = (state_reg == DONE);
  assign pass            = done && (err_count_reg == '0);
  assign err_count       = err_count_reg;
  assign first_err_index = first_err_index_reg;
  assign first_err_data  = first_err_data_reg;

endmodule
